// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular FIFO of fetch packets between next-PC and decode.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        enq_valid_i,
    input  logic [31:0] enq_pc_i,
    input  logic [63:0] enq_inst_i,
    input  logic        enq_taken_i,
    input  logic [31:0] enq_npc_i,
    output logic        stall_o,
    input  logic        deq_ready_i,
    output logic        deq_valid_o,
    output logic [31:0] deq_pc_o,
    output logic [63:0] deq_inst_o,
    output logic [1:0]  deq_mask_o,
    output logic        deq_taken_o,
    output logic [31:0] deq_npc_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
        logic        taken;
        logic [31:0] npc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            empty;
    logic            enq_fire;
    logic            wr_en;
    logic            rd_en;
    entry_t          enq_entry;
    entry_t          head_entry;

    assign empty    = (count_q == '0);
    assign stall_o  = (count_q == CntFull);
    assign enq_fire = enq_valid_i && !stall_o && !flush_i;

    // Entering at the upper word means the lower slot precedes the fetch target.
    always_comb begin
        enq_entry.pc    = enq_pc_i;
        enq_entry.inst  = enq_inst_i;
        enq_entry.mask  = enq_pc_i[2] ? 2'b10 : 2'b11;
        enq_entry.taken = enq_taken_i;
        enq_entry.npc   = enq_npc_i;
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    assign deq_valid_o = (!empty || enq_valid_i) && !flush_i;
    assign head_entry  = empty ? enq_entry : mem_q[rd_ptr_q];
    // A packet consumed straight off the bypass never occupies a slot.
    assign wr_en       = enq_fire && !(empty && deq_ready_i);
    assign rd_en       = deq_valid_o && deq_ready_i && !empty;
`else
    assign deq_valid_o = !empty && !flush_i;
    assign head_entry  = mem_q[rd_ptr_q];
    assign wr_en       = enq_fire;
    assign rd_en       = deq_valid_o && deq_ready_i;
`endif

    assign deq_pc_o    = head_entry.pc;
    assign deq_inst_o  = head_entry.inst;
    assign deq_mask_o  = head_entry.mask;
    assign deq_taken_o = head_entry.taken;
    assign deq_npc_o   = head_entry.npc;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= enq_entry;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        enq_valid_i;
    logic [31:0] enq_pc_i;
    logic [63:0] enq_inst_i;
    logic        enq_taken_i;
    logic [31:0] enq_npc_i;
    logic        stall_o;
    logic        deq_ready_i;
    logic        deq_valid_o;
    logic [31:0] deq_pc_o;
    logic [63:0] deq_inst_o;
    logic [1:0]  deq_mask_o;
    logic        deq_taken_o;
    logic [31:0] deq_npc_o;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_pc_i    (enq_pc_i),
        .enq_inst_i  (enq_inst_i),
        .enq_taken_i (enq_taken_i),
        .enq_npc_i   (enq_npc_i),
        .stall_o     (stall_o),
        .deq_ready_i (deq_ready_i),
        .deq_valid_o (deq_valid_o),
        .deq_pc_o    (deq_pc_o),
        .deq_inst_o  (deq_inst_o),
        .deq_mask_o  (deq_mask_o),
        .deq_taken_o (deq_taken_o),
        .deq_npc_o   (deq_npc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
        logic        taken;
        logic [31:0] npc;
    } pkt_t;

    pkt_t model_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check outputs against the model, clock, advance the model.
    task automatic cycle(input logic fl, input logic ev, input logic [31:0] pc, input logic rdy);
        pkt_t p;
        pkt_t head;
        logic exp_valid;
        logic exp_stall;
        logic enq;
        logic deq;
        int   sz;
        p.pc    = pc;
        p.inst  = {$urandom(), $urandom()};
        p.taken = 1'($urandom_range(0, 1));
        p.npc   = $urandom();
        flush_i     = fl;
        enq_valid_i = ev;
        enq_pc_i    = p.pc;
        enq_inst_i  = p.inst;
        enq_taken_i = p.taken;
        enq_npc_i   = p.npc;
        deq_ready_i = rdy;
        #1;
        sz        = model_q.size();
        exp_stall = (sz == DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
        exp_valid = (sz != 0 || ev) && !fl;
`else
        exp_valid = (sz != 0) && !fl;
`endif
        if (sz != 0) head = model_q[0];
        else head = p;
        check_eq("stall", 64'(stall_o), 64'(exp_stall));
        check_eq("deq_valid", 64'(deq_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            check_eq("deq_pc", 64'(deq_pc_o), 64'(head.pc));
            check_eq("deq_inst", deq_inst_o, head.inst);
            check_eq("deq_mask", 64'(deq_mask_o), head.pc[2] ? 64'h2 : 64'h3);
            check_eq("deq_taken", 64'(deq_taken_o), 64'(head.taken));
            check_eq("deq_npc", 64'(deq_npc_o), 64'(head.npc));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            enq = ev && !exp_stall;
            deq = exp_valid && rdy;
            if (!(enq && deq && sz == 0)) begin
                if (deq) void'(model_q.pop_front());
                if (enq) model_q.push_back(p);
            end
        end
    endtask

    task automatic idle();
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] exp_pcs [4];
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        enq_pc_i    = '0;
        enq_inst_i  = '0;
        enq_taken_i = 1'b0;
        enq_npc_i   = '0;
        deq_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state and first packet
        idle();
        check_eq("reset_valid", 64'(deq_valid_o), 64'h0);
        check_eq("reset_stall", 64'(stall_o), 64'h0);
        cycle(1'b0, 1'b1, 32'h1c00_0000, 1'b0);
        idle();
        check_eq("first_valid", 64'(deq_valid_o), 64'h1);
        check_eq("first_pc", 64'(deq_pc_o), 64'h1c00_0000);
        check_eq("first_mask", 64'(deq_mask_o), 64'h3);

        // Fill to DEPTH, then a dropped enqueue
        cycle(1'b0, 1'b1, 32'h1c00_0008, 1'b0);
        cycle(1'b0, 1'b1, 32'h1c00_0010, 1'b0);
        cycle(1'b0, 1'b1, 32'h1c00_0018, 1'b0);
        idle();
        check_eq("full_stall", 64'(stall_o), 64'h1);
        cycle(1'b0, 1'b1, 32'h1c00_0020, 1'b0);

        // Full with enq+deq: head leaves, enqueue rejected
        cycle(1'b0, 1'b1, 32'h1c00_0020, 1'b1);
        idle();
        check_eq("full_deq_stall", 64'(stall_o), 64'h0);
        check_eq("full_deq_head", 64'(deq_pc_o), 64'h1c00_0008);
        exp_pcs[0] = 32'h1c00_0008;
        exp_pcs[1] = 32'h1c00_0010;
        exp_pcs[2] = 32'h1c00_0018;
        for (int i = 0; i < 3; i++) begin
            idle();
            check_eq("drain_pc", 64'(deq_pc_o), 64'(exp_pcs[i]));
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        idle();
        check_eq("drained_valid", 64'(deq_valid_o), 64'h0);

        // Mask rule
        cycle(1'b0, 1'b1, 32'h1c00_0004, 1'b0);
        idle();
        check_eq("mask_hi", 64'(deq_mask_o), 64'h2);
        cycle(1'b0, 1'b1, 32'h1c00_0008, 1'b1);
        idle();
        check_eq("mask_lo", 64'(deq_mask_o), 64'h3);
        check_eq("mask_lo_pc", 64'(deq_pc_o), 64'h1c00_0008);

        // Flush with 3 entries and a competing enqueue
        cycle(1'b0, 1'b1, 32'h1c00_0010, 1'b0);
        cycle(1'b0, 1'b1, 32'h1c00_0018, 1'b0);
        flush_i     = 1'b1;
        enq_valid_i = 1'b1;
        #1;
        check_eq("flush_valid", 64'(deq_valid_o), 64'h0);
        cycle(1'b1, 1'b1, 32'h1c00_0040, 1'b1);
        idle();
        check_eq("post_flush_valid", 64'(deq_valid_o), 64'h0);
        check_eq("post_flush_stall", 64'(stall_o), 64'h0);
        cycle(1'b0, 1'b1, 32'h2000_0000, 1'b0);
        idle();
        check_eq("target_head", 64'(deq_pc_o), 64'h2000_0000);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Empty queue, enq with ready: bypass shows it at once, otherwise one cycle later
        cycle(1'b0, 1'b1, 32'h1c00_0100, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Asynchronous reset mid-operation
        cycle(1'b0, 1'b1, 32'h1c00_0200, 1'b0);
        cycle(1'b0, 1'b1, 32'h1c00_0208, 1'b0);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(deq_valid_o), 64'h0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int n = 0; n < 10000; n++) begin
            cycle(1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 9) < 7),
                  {$urandom() & 32'hffff_fffc},
                  1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
